// File: rtl/midi_voice_allocator.sv
// ---------------------------------------------------------------------------
// midi_voice_allocator
//
// Polyphonic voice allocator for a MIDI synth. One note message is accepted
// at a time. After acceptance, the allocator scans the voice table one voice
// per cycle and collects the facts it needs:
//   - the lowest-index active voice that already holds the note
//   - the lowest-index free voice
//   - the mask of active voices holding the note
//   - the oldest active voice (steal build only)
// It then commits the result in a single ASSIGN cycle.
//
// Timing relative to the accepting edge E0:
//   - E1..E(NUM_VOICES) scan voices 0..NUM_VOICES-1.
//   - E(NUM_VOICES+1) updates the voice table, pulses o_drop/o_steal and
//     returns to IDLE.
//
// Optional feature macro: VOICE_STEAL_EN
//   defined   : a note-on with every voice busy (and no retrigger match)
//               steals the oldest voice and pulses o_steal.
//   undefined : that note-on is discarded with an o_drop pulse; o_steal is
//               tied low and the age search hardware is not built.
//
// Parameters:
//   NUM_VOICES  number of voices (2..16)
//   AGE_W       width of each voice's saturating age counter
//
// Ports:
//   i_clk         clock
//   i_reset       synchronous active-high reset
//   i_msg_valid   a note message is presented
//   o_msg_ready   allocator idle, message accepted on valid & ready
//   i_note_on     1 = note-on, 0 = note-off
//   i_note        MIDI note number
//   i_velocity    MIDI velocity (note-on with velocity 0 is a note-off)
//   o_voice_gate  per-voice gate
//   o_voice_note  per-voice note, voice k at [7k+6:7k]
//   o_voice_vel   per-voice velocity, packed like o_voice_note
//   o_drop        one-cycle pulse: note-on discarded
//   o_steal       one-cycle pulse: active voice reassigned
// ---------------------------------------------------------------------------
module midi_voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int AGE_W      = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_msg_valid,
    output logic                    o_msg_ready,
    input  logic                    i_note_on,
    input  logic [6:0]              i_note,
    input  logic [6:0]              i_velocity,
    output logic [NUM_VOICES-1:0]   o_voice_gate,
    output logic [7*NUM_VOICES-1:0] o_voice_note,
    output logic [7*NUM_VOICES-1:0] o_voice_vel,
    output logic                    o_drop,
    output logic                    o_steal
);

    localparam int               IDX_W    = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        ASSIGN = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Voice table
    logic             gate_reg [NUM_VOICES];
    logic [6:0]       note_reg [NUM_VOICES];
    logic [6:0]       vel_reg  [NUM_VOICES];
    logic [AGE_W-1:0] age_reg  [NUM_VOICES];

    // Captured message; msg_on_reg already folds velocity 0 into note-off.
    logic       msg_on_reg;
    logic [6:0] msg_note_reg;
    logic [6:0] msg_vel_reg;

    // Scan state and accumulated results
    logic [IDX_W-1:0]      scan_idx_reg;
    logic                  hit_found_reg;
    logic [IDX_W-1:0]      hit_idx_reg;
    logic                  free_found_reg;
    logic [IDX_W-1:0]      free_idx_reg;
    logic [NUM_VOICES-1:0] off_mask_reg;
`ifdef VOICE_STEAL_EN
    logic                  old_found_reg;
    logic [IDX_W-1:0]      old_idx_reg;
    logic [AGE_W-1:0]      old_age_reg;
    logic                  steal_reg;
`endif

    logic drop_reg;

    // Decision made in ASSIGN from the scan results
    logic             tgt_valid;
    logic [IDX_W-1:0] tgt_idx;
    logic             drop_now;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        o_msg_ready = 1'b0;
        case (state_reg)
            IDLE: begin
                o_msg_ready = 1'b1;
                if (i_msg_valid) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (scan_idx_reg == LAST_IDX) begin
                    state_next = ASSIGN;
                end
            end
            ASSIGN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------ target choice
    // Priority: retrigger match, then free voice, then steal or drop.
    always_comb begin
        tgt_valid = 1'b0;
        tgt_idx   = '0;
        drop_now  = 1'b0;
        if (msg_on_reg) begin
            if (hit_found_reg) begin
                tgt_valid = 1'b1;
                tgt_idx   = hit_idx_reg;
            end else if (free_found_reg) begin
                tgt_valid = 1'b1;
                tgt_idx   = free_idx_reg;
            end else begin
`ifdef VOICE_STEAL_EN
                tgt_valid = 1'b1;
                tgt_idx   = old_idx_reg;
`else
                drop_now  = 1'b1;
`endif
            end
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < NUM_VOICES; k++) begin
                gate_reg[k] <= 1'b0;
                note_reg[k] <= '0;
                vel_reg[k]  <= '0;
                age_reg[k]  <= '0;
            end
            msg_on_reg     <= 1'b0;
            msg_note_reg   <= '0;
            msg_vel_reg    <= '0;
            scan_idx_reg   <= '0;
            hit_found_reg  <= 1'b0;
            hit_idx_reg    <= '0;
            free_found_reg <= 1'b0;
            free_idx_reg   <= '0;
            off_mask_reg   <= '0;
            drop_reg       <= 1'b0;
`ifdef VOICE_STEAL_EN
            old_found_reg  <= 1'b0;
            old_idx_reg    <= '0;
            old_age_reg    <= '0;
            steal_reg      <= 1'b0;
`endif
        end else begin
            drop_reg  <= 1'b0;
`ifdef VOICE_STEAL_EN
            steal_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (i_msg_valid) begin
                        msg_on_reg     <= i_note_on && (i_velocity != 7'd0);
                        msg_note_reg   <= i_note;
                        msg_vel_reg    <= i_velocity;
                        scan_idx_reg   <= '0;
                        hit_found_reg  <= 1'b0;
                        free_found_reg <= 1'b0;
                        off_mask_reg   <= '0;
`ifdef VOICE_STEAL_EN
                        old_found_reg  <= 1'b0;
`endif
                    end
                end
                SCAN: begin
                    scan_idx_reg <= scan_idx_reg + 1'b1;
                    if (gate_reg[scan_idx_reg]) begin
                        if (note_reg[scan_idx_reg] == msg_note_reg) begin
                            off_mask_reg[scan_idx_reg] <= 1'b1;
                            if (!hit_found_reg) begin
                                hit_found_reg <= 1'b1;
                                hit_idx_reg   <= scan_idx_reg;
                            end
                        end
`ifdef VOICE_STEAL_EN
                        // Strict compare keeps the lowest index on age ties.
                        if (!old_found_reg || (age_reg[scan_idx_reg] > old_age_reg)) begin
                            old_found_reg <= 1'b1;
                            old_idx_reg   <= scan_idx_reg;
                            old_age_reg   <= age_reg[scan_idx_reg];
                        end
`endif
                    end else if (!free_found_reg) begin
                        free_found_reg <= 1'b1;
                        free_idx_reg   <= scan_idx_reg;
                    end
                end
                ASSIGN: begin
                    if (!msg_on_reg) begin
                        for (int k = 0; k < NUM_VOICES; k++) begin
                            if (off_mask_reg[k]) begin
                                gate_reg[k] <= 1'b0;
                            end
                        end
                    end else if (tgt_valid) begin
                        for (int k = 0; k < NUM_VOICES; k++) begin
                            if (IDX_W'(k) == tgt_idx) begin
                                gate_reg[k] <= 1'b1;
                                note_reg[k] <= msg_note_reg;
                                vel_reg[k]  <= msg_vel_reg;
                                age_reg[k]  <= '0;
                            end else if (gate_reg[k] && (age_reg[k] != AGE_MAX)) begin
                                age_reg[k]  <= age_reg[k] + 1'b1;
                            end
                        end
`ifdef VOICE_STEAL_EN
                        // Only reachable with every voice busy and no match.
                        steal_reg <= !hit_found_reg && !free_found_reg;
`endif
                    end
                    drop_reg <= drop_now;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------ outputs
    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice_out
            assign o_voice_gate[gi]       = gate_reg[gi];
            assign o_voice_note[7*gi +: 7] = note_reg[gi];
            assign o_voice_vel[7*gi +: 7]  = vel_reg[gi];
        end
    endgenerate

    assign o_drop = drop_reg;
`ifdef VOICE_STEAL_EN
    assign o_steal = steal_reg;
`else
    assign o_steal = 1'b0;
`endif

endmodule

// File: tb/tb_midi_voice_allocator.sv
// ---------------------------------------------------------------------------
// tb_midi_voice_allocator
//
// Directed bench for midi_voice_allocator (NUM_VOICES=8). Each message is
// sent through send_msg, which records the busy length, the ready level when
// the allocator returns to IDLE, and how many sampled cycles o_drop/o_steal
// were high around the transaction. It prints one line per transaction.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_midi_voice_allocator;

    localparam int NV = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          msg_valid;
    logic          msg_ready;
    logic          note_on;
    logic [6:0]    note;
    logic [6:0]    vel;
    logic [NV-1:0] voice_gate;
    logic [7*NV-1:0] voice_note;
    logic [7*NV-1:0] voice_vel;
    logic          drop;
    logic          steal;

    int n_tests = 0;
    int n_fail  = 0;

    // Results of the most recent send_msg
    int   busy_cycles;
    logic ready_at_end;
    int   drop_cnt;
    int   steal_cnt;

    midi_voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_msg_valid  (msg_valid),
        .o_msg_ready  (msg_ready),
        .i_note_on    (note_on),
        .i_note       (note),
        .i_velocity   (vel),
        .o_voice_gate (voice_gate),
        .o_voice_note (voice_note),
        .o_voice_vel  (voice_vel),
        .o_drop       (drop),
        .o_steal      (steal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] note_of(input int k);
        return voice_note[7*k +: 7];
    endfunction

    function automatic logic [6:0] vel_of(input int k);
        return voice_vel[7*k +: 7];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Presents one message, then follows it until the allocator is idle again,
    // plus one further cycle so a pulse that lingers is counted.
    task automatic send_msg(input logic on, input logic [6:0] n, input logic [6:0] v);
        int cyc;
        @(negedge clk);
        msg_valid = 1'b1;
        note_on   = on;
        note      = n;
        vel       = v;
        @(posedge clk);
        #1;
        msg_valid = 1'b0;
        drop_cnt  = int'(drop);
        steal_cnt = int'(steal);
        cyc = 0;
        while (!msg_ready && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
            drop_cnt  += int'(drop);
            steal_cnt += int'(steal);
        end
        busy_cycles  = cyc;
        ready_at_end = msg_ready;
        if (cyc >= 50) begin
            check("timeout", 64'(cyc), 64'd9);
        end
        @(posedge clk);
        #1;
        drop_cnt  += int'(drop);
        steal_cnt += int'(steal);
        $display("[TB] msg on=%0b note=%0d vel=%0d busy=%0d gate=%b drop=%0d steal=%0d",
                 on, n, v, busy_cycles, voice_gate, drop_cnt, steal_cnt);
    endtask

    logic [7*NV-1:0] notes_before;

    initial begin
        rst       = 1'b0;
        msg_valid = 1'b0;
        note_on   = 1'b0;
        note      = '0;
        vel       = '0;

        // Reset state
        do_reset();
        check("rst_ready", 64'(msg_ready), 64'd1);
        check("rst_gate", 64'(voice_gate), 64'd0);
        check("rst_notes", 64'(voice_note), 64'd0);
        check("rst_vels", 64'(voice_vel), 64'd0);
        check("rst_drop", 64'(drop), 64'd0);
        check("rst_steal", 64'(steal), 64'd0);

        // First note-on: 9 busy cycles, lands in voice 0
        send_msg(1'b1, 7'd60, 7'd100);
        check("on60_busy", 64'(busy_cycles), 64'd9);
        check("on60_ready", 64'(ready_at_end), 64'd1);
        check("on60_gate", 64'(voice_gate), 64'h01);
        check("on60_note0", 64'(note_of(0)), 64'd60);
        check("on60_vel0", 64'(vel_of(0)), 64'd100);
        check("on60_drop", 64'(drop_cnt), 64'd0);
        check("on60_steal", 64'(steal_cnt), 64'd0);

        send_msg(1'b1, 7'd62, 7'd90);
        check("on62_gate", 64'(voice_gate), 64'h03);
        send_msg(1'b1, 7'd64, 7'd80);
        check("on64_gate", 64'(voice_gate), 64'h07);
        check("on64_note2", 64'(note_of(2)), 64'd64);
        send_msg(1'b0, 7'd62, 7'd0);
        check("off62_gate", 64'(voice_gate), 64'h05);
        check("off62_note1", 64'(note_of(1)), 64'd62);

        // Velocity-0 note-on behaves as note-off
        send_msg(1'b1, 7'd64, 7'd0);
        check("v0_gate", 64'(voice_gate), 64'h01);
        check("v0_drop", 64'(drop_cnt), 64'd0);

        // Retrigger voice 0 instead of using free voice 1
        send_msg(1'b1, 7'd60, 7'd20);
        check("retrig_gate", 64'(voice_gate), 64'h01);
        check("retrig_note0", 64'(note_of(0)), 64'd60);
        check("retrig_vel0", 64'(vel_of(0)), 64'd20);

        // Note-off with no match changes nothing
        notes_before = voice_note;
        send_msg(1'b0, 7'd99, 7'd5);
        check("offmiss_gate", 64'(voice_gate), 64'h01);
        check("offmiss_notes", 64'(voice_note), 64'(notes_before));

        // Fill all voices, then one more note-on
        do_reset();
        for (int i = 0; i < NV; i++) begin
            send_msg(1'b1, 7'(40 + i), 7'(10 + i));
        end
        check("fill_gate", 64'(voice_gate), 64'hFF);
        for (int i = 0; i < NV; i++) begin
            check($sformatf("fill_note%0d", i), 64'(note_of(i)), 64'(40 + i));
        end
        notes_before = voice_note;
        send_msg(1'b1, 7'd50, 7'd99);
        check("full_gate", 64'(voice_gate), 64'hFF);
`ifdef VOICE_STEAL_EN
        check("steal_note0", 64'(note_of(0)), 64'd50);
        check("steal_vel0", 64'(vel_of(0)), 64'd99);
        check("steal_note1", 64'(note_of(1)), 64'd41);
        check("steal_pulse", 64'(steal_cnt), 64'd1);
        check("steal_nodrop", 64'(drop_cnt), 64'd0);
        // Voice 1 is now oldest (age 7 vs. others lower)
        send_msg(1'b1, 7'd51, 7'd33);
        check("steal2_note1", 64'(note_of(1)), 64'd51);
        check("steal2_note0", 64'(note_of(0)), 64'd50);
`else
        check("drop_notes", 64'(voice_note), 64'(notes_before));
        check("drop_vel0", 64'(vel_of(0)), 64'd10);
        check("drop_pulse", 64'(drop_cnt), 64'd1);
        check("drop_nosteal", 64'(steal_cnt), 64'd0);
`endif

        // Reset in the middle of a scan aborts the message
        do_reset();
        @(negedge clk);
        msg_valid = 1'b1;
        note_on   = 1'b1;
        note      = 7'd70;
        vel       = 7'd50;
        @(posedge clk);          // E0
        #1;
        msg_valid = 1'b0;
        check("abort_busy", 64'(msg_ready), 64'd0);
        repeat (3) @(posedge clk); // E1..E3
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk); // E4 sampled in reset
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ready", 64'(msg_ready), 64'd1);
        check("abort_gate", 64'(voice_gate), 64'd0);
        repeat (12) @(posedge clk);
        #1;
        check("abort_gate_late", 64'(voice_gate), 64'd0);
        check("abort_notes_late", 64'(voice_note), 64'd0);
        $display("[TB] abort reset at E4 gate=%b ready=%0b", voice_gate, msg_ready);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
